// File: rtl/serv_ext_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | serv_ext_arbiter : round-robin share of one extension unit by two     |
// |                    requesters, with optional ISSUE-phase timeout      |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module serv_ext_arbiter #(
   parameter int TIMEOUT = 0,
   parameter int TW      = 8
) (
   input  logic        clk,
   input  logic        i_rst,
   input  logic        i_valid0,
   input  logic        i_valid1,
   input  logic [31:0] i_rs1_0,
   input  logic [31:0] i_rs2_0,
   input  logic [31:0] i_rs1_1,
   input  logic [31:0] i_rs2_1,
   input  logic [2:0]  i_funct3_0,
   input  logic [2:0]  i_funct3_1,
   output logic        o_ready0,
   output logic        o_ready1,
   output logic [31:0] o_rd0,
   output logic [31:0] o_rd1,
   output logic        o_err0,
   output logic        o_err1,
   output logic        o_ext_valid,
   output logic [31:0] o_ext_rs1,
   output logic [31:0] o_ext_rs2,
   output logic [2:0]  o_ext_funct3,
   input  logic [31:0] i_ext_rd,
   input  logic        i_ext_ready,
   output logic        o_busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RET   = 2'd2
   } state_t;

   localparam bit            TO_EN   = (TIMEOUT > 0);
   localparam logic [TW-1:0] TO_LAST = TO_EN ? TW'(TIMEOUT - 1) : '0;

   state_t        state_q, state_d;
   logic          grant_q, grant_d;
   logic          prio_q, prio_d;
   logic [1:0]    block_q, block_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          ext_valid_q, ext_valid_d;
   logic [31:0]   ext_rs1_q, ext_rs1_d;
   logic [31:0]   ext_rs2_q, ext_rs2_d;
   logic [2:0]    ext_funct3_q, ext_funct3_d;
   logic [1:0]    ready_q, ready_d;
   logic [1:0]    err_q, err_d;
   logic [31:0]   rd0_q, rd0_d;
   logic [31:0]   rd1_q, rd1_d;

   logic [1:0]    elig;
   logic          win;
   logic          timeout_hit;
   logic [31:0]   res;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      prio_d       = prio_q;
      block_d      = block_q;
      cnt_d        = cnt_q;
      ext_valid_d  = ext_valid_q;
      ext_rs1_d    = ext_rs1_q;
      ext_rs2_d    = ext_rs2_q;
      ext_funct3_d = ext_funct3_q;
      ready_d      = '0;
      err_d        = '0;
      rd0_d        = '0;
      rd1_d        = '0;
      elig         = {i_valid1, i_valid0} & ~block_q;
      win          = 1'b0;
      timeout_hit  = TO_EN && (cnt_q == TO_LAST);
      res          = '0;

      unique case (state_q)
         IDLE: begin
            // The mask only shields the single cycle after RET, when the
            // served requester's valid is still high.
            block_d = '0;
            if (|elig) begin
               win          = (&elig) ? prio_q : elig[1];
               grant_d      = win;
               prio_d       = ~win;
               cnt_d        = '0;
               state_d      = ISSUE;
               ext_valid_d  = 1'b1;
               ext_rs1_d    = win ? i_rs1_1 : i_rs1_0;
               ext_rs2_d    = win ? i_rs2_1 : i_rs2_0;
               ext_funct3_d = win ? i_funct3_1 : i_funct3_0;
            end
         end
         ISSUE: begin
            if (i_ext_ready || timeout_hit) begin
               // A strobe on the timeout cycle still delivers a real result.
               res          = i_ext_ready ? i_ext_rd : 32'hFFFF_FFFF;
               state_d      = RET;
               ext_valid_d  = 1'b0;
               ext_rs1_d    = '0;
               ext_rs2_d    = '0;
               ext_funct3_d = '0;
               ready_d      = grant_q ? 2'b10 : 2'b01;
               err_d        = i_ext_ready ? 2'b00 : (grant_q ? 2'b10 : 2'b01);
               if (grant_q) rd1_d = res;
               else         rd0_d = res;
            end else if (TO_EN) begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         RET: begin
            state_d = IDLE;
            block_d = grant_q ? 2'b10 : 2'b01;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         prio_q       <= 1'b0;
         block_q      <= '0;
         cnt_q        <= '0;
         ext_valid_q  <= 1'b0;
         ext_rs1_q    <= '0;
         ext_rs2_q    <= '0;
         ext_funct3_q <= '0;
         ready_q      <= '0;
         err_q        <= '0;
         rd0_q        <= '0;
         rd1_q        <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         prio_q       <= prio_d;
         block_q      <= block_d;
         cnt_q        <= cnt_d;
         ext_valid_q  <= ext_valid_d;
         ext_rs1_q    <= ext_rs1_d;
         ext_rs2_q    <= ext_rs2_d;
         ext_funct3_q <= ext_funct3_d;
         ready_q      <= ready_d;
         err_q        <= err_d;
         rd0_q        <= rd0_d;
         rd1_q        <= rd1_d;
      end
   end

   assign o_ext_valid  = ext_valid_q;
   assign o_ext_rs1    = ext_rs1_q;
   assign o_ext_rs2    = ext_rs2_q;
   assign o_ext_funct3 = ext_funct3_q;
   assign o_ready0     = ready_q[0];
   assign o_ready1     = ready_q[1];
   assign o_err0       = err_q[0];
   assign o_err1       = err_q[1];
   assign o_rd0        = rd0_q;
   assign o_rd1        = rd1_q;
   assign o_busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serv_ext_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_serv_ext_arbiter : directed scenarios plus randomized traffic      |
// |                       against a transaction-level reference model     |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_serv_ext_arbiter;

   localparam int TO = 4;

   logic        clk;
   logic        rst;
   logic [1:0]  v;
   logic [31:0] rs1 [2];
   logic [31:0] rs2 [2];
   logic [2:0]  f3  [2];
   logic        er;
   logic [31:0] erd;

   logic        o_ready0, o_ready1, o_err0, o_err1, o_ext_valid, o_busy;
   logic [31:0] o_rd0, o_rd1, o_ext_rs1, o_ext_rs2;
   logic [2:0]  o_ext_funct3;

   int n_pass  = 0;
   int n_total = 0;

   // stimulus control: 0 = quiet, 1 = scripted requests, 2 = random traffic
   int mode = 0;
   bit fixed_ops = 0;
   int rel [2];
   int reqs_left [2];

   // monitor
   int ev_cnt, r0_cnt, r1_cnt;
   logic [31:0] last_rd0, last_rd1;
   logic last_err0, last_err1;
   int glog [$];

   serv_ext_arbiter #(.TIMEOUT(TO), .TW(8)) dut (
      .clk          (clk),
      .i_rst        (rst),
      .i_valid0     (v[0]),
      .i_valid1     (v[1]),
      .i_rs1_0      (rs1[0]),
      .i_rs2_0      (rs2[0]),
      .i_rs1_1      (rs1[1]),
      .i_rs2_1      (rs2[1]),
      .i_funct3_0   (f3[0]),
      .i_funct3_1   (f3[1]),
      .o_ready0     (o_ready0),
      .o_ready1     (o_ready1),
      .o_rd0        (o_rd0),
      .o_rd1        (o_rd1),
      .o_err0       (o_err0),
      .o_err1       (o_err1),
      .o_ext_valid  (o_ext_valid),
      .o_ext_rs1    (o_ext_rs1),
      .o_ext_rs2    (o_ext_rs2),
      .o_ext_funct3 (o_ext_funct3),
      .i_ext_rd     (erd),
      .i_ext_ready  (er),
      .o_busy       (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one transaction at a time, owner -1 when nobody holds the unit.
   typedef struct {
      int          owner;
      bit          in_ret;
      int          issue_n;
      logic [31:0] rs1, rs2, res;
      logic [2:0]  f3;
      bit          err;
      int          favour;
      int          blocked;
   } model_t;

   function automatic model_t model_reset();
      model_t m;
      m.owner = -1; m.in_ret = 0; m.issue_n = 0;
      m.rs1 = '0; m.rs2 = '0; m.res = '0; m.f3 = '0;
      m.err = 0; m.favour = 0; m.blocked = -1;
      return m;
   endfunction

   function automatic model_t model_step(model_t m, logic [1:0] vv, logic [31:0] a0, logic [31:0] b0,
                                         logic [2:0] c0, logic [31:0] a1, logic [31:0] b1,
                                         logic [2:0] c1, logic ack, logic [31:0] ack_rd);
      model_t n;
      bit e0, e1;
      n = m;
      if (m.in_ret) begin
         n.in_ret  = 0;
         n.blocked = m.owner;
         n.owner   = -1;
      end else if (m.owner < 0) begin
         e0 = vv[0] && (m.blocked != 0);
         e1 = vv[1] && (m.blocked != 1);
         n.blocked = -1;
         if (e0 || e1) begin
            n.owner   = (e0 && e1) ? m.favour : (e0 ? 0 : 1);
            n.favour  = 1 - n.owner;
            n.rs1     = (n.owner == 0) ? a0 : a1;
            n.rs2     = (n.owner == 0) ? b0 : b1;
            n.f3      = (n.owner == 0) ? c0 : c1;
            n.issue_n = 0;
         end
      end else begin
         n.issue_n = m.issue_n + 1;
         if (ack) begin
            n.res = ack_rd; n.err = 0; n.in_ret = 1;
         end else if (n.issue_n == TO) begin
            n.res = 32'hFFFF_FFFF; n.err = 1; n.in_ret = 1;
         end
      end
      return n;
   endfunction

   model_t m;
   always @(posedge clk or posedge rst) begin
      if (rst) m <= model_reset();
      else     m <= model_step(m, v, rs1[0], rs2[0], f3[0], rs1[1], rs2[1], f3[1], er, erd);
   end

   task automatic chk(input string name, input logic [139:0] act, input logic [139:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   logic [67:0] exp_ext, exp_ret;
   initial forever begin
      @(negedge clk);
      exp_ext = (m.owner >= 0 && !m.in_ret) ? {1'b1, m.rs1, m.rs2, m.f3} : '0;
      exp_ret = '0;
      if (m.in_ret) begin
         if (m.owner == 0) exp_ret = {1'b1, m.res, m.err, 34'b0};
         else              exp_ret = {34'b0, 1'b1, m.res, m.err};
      end
      chk("ext_port", {o_ext_valid, o_ext_rs1, o_ext_rs2, o_ext_funct3}, exp_ext);
      chk("ret_port", {o_ready0, o_rd0, o_err0, o_ready1, o_rd1, o_err1}, exp_ret);
      chk("busy", o_busy, (m.owner >= 0));
   end

   initial forever begin
      @(negedge clk);
      if (o_ext_valid) ev_cnt++;
      if (o_ready0) begin
         r0_cnt++; last_rd0 = o_rd0; last_err0 = o_err0; glog.push_back(0);
         rel[0] = (mode == 2) ? int'($urandom_range(1, 2)) : 2;
      end
      if (o_ready1) begin
         r1_cnt++; last_rd1 = o_rd1; last_err1 = o_err1; glog.push_back(1);
         rel[1] = (mode == 2) ? int'($urandom_range(1, 2)) : 2;
      end
   end

   // Requesters hold valid until served and release it one cycle late.
   initial forever begin
      @(posedge clk);
      #1;
      if (mode == 2) begin
         er  = ($urandom_range(0, 3) == 0);
         erd = $urandom;
      end
      if (mode != 0) begin
         for (int n = 0; n < 2; n++) begin
            if (rel[n] > 0) begin
               rel[n]--;
               if (rel[n] == 0) v[n] = 1'b0;
            end else if (v[n] && mode == 2 && $urandom_range(0, 19) == 0) begin
               v[n] = 1'b0;
            end else if (!v[n] && ((mode == 2 && $urandom_range(0, 2) == 0) ||
                                   (mode == 1 && reqs_left[n] > 0))) begin
               v[n] = 1'b1;
               if (mode == 1) reqs_left[n]--;
               if (!(mode == 1 && fixed_ops)) begin
                  rs1[n] = $urandom; rs2[n] = $urandom; f3[n] = 3'($urandom);
               end
            end
         end
      end
   end

   function automatic int pack_log();
      int p = 0;
      foreach (glog[i]) p = (p << 1) | glog[i];
      return p;
   endfunction

   task automatic clear_mon();
      ev_cnt = 0; r0_cnt = 0; r1_cnt = 0;
      last_rd0 = '0; last_rd1 = '0; last_err0 = 0; last_err1 = 0;
      glog.delete();
   endtask

   task automatic quiet_inputs();
      mode = 0; er = 0; erd = '0; fixed_ops = 0;
      for (int n = 0; n < 2; n++) begin
         v[n] = 1'b0; rel[n] = 0; reqs_left[n] = 0;
         rs1[n] = '0; rs2[n] = '0; f3[n] = '0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst = 1'b1;
      quiet_inputs();
      @(negedge clk);
      chk("reset_outputs", {o_ready0, o_rd0, o_err0, o_ready1, o_rd1, o_err1, o_ext_valid,
                            o_ext_rs1, o_ext_rs2, o_ext_funct3, o_busy}, '0);
      @(posedge clk); #2;
      rst = 1'b0;
      clear_mon();
   endtask

   task automatic wait_ext_valid();
      for (int i = 0; i < 30 && !o_ext_valid; i++) @(negedge clk);
      chk("wait_ext_valid", o_ext_valid, 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      quiet_inputs();
      clear_mon();
      repeat (2) @(posedge clk);

      // single request: ack in the second ISSUE cycle
      do_reset();
      fixed_ops = 1; rs1[0] = 32'd7; rs2[0] = 32'd6; f3[0] = 3'd0;
      reqs_left[0] = 1; mode = 1;
      wait_ext_valid();
      chk("single_ops", {o_ext_rs1, o_ext_rs2, o_ext_funct3}, {32'd7, 32'd6, 3'd0});
      @(posedge clk); #2; er = 1'b1; erd = 32'd42;
      @(posedge clk); #2; er = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      chk("single_ext_cycles", ev_cnt, 2);
      chk("single_ready0", r0_cnt, 1);
      chk("single_rd0", last_rd0, 32'd42);
      chk("single_err0", last_err0, 1'b0);
      chk("single_ready1", r1_cnt, 0);

      // tie after reset
      do_reset();
      er = 1'b1; erd = 32'h1234; reqs_left[0] = 1; reqs_left[1] = 1; mode = 1;
      for (int i = 0; i < 40 && glog.size() < 2; i++) @(negedge clk);
      repeat (6) @(posedge clk);
      #2;
      chk("tie_count", glog.size(), 2);
      chk("tie_order", pack_log(), 32'b01);

      // fairness: two requests each
      do_reset();
      er = 1'b1; erd = 32'h55; reqs_left[0] = 2; reqs_left[1] = 2; mode = 1;
      for (int i = 0; i < 80 && glog.size() < 4; i++) @(negedge clk);
      repeat (6) @(posedge clk);
      #2;
      chk("fair_count", glog.size(), 4);
      chk("fair_order", pack_log(), 32'b0101);

      // timeout: unit never answers
      do_reset();
      reqs_left[1] = 1; mode = 1;
      for (int i = 0; i < 30 && r1_cnt == 0; i++) @(negedge clk);
      repeat (4) @(posedge clk);
      #2;
      chk("timeout_ready1", r1_cnt, 1);
      chk("timeout_ext_cycles", ev_cnt, TO);
      chk("timeout_rd1", last_rd1, 32'hFFFF_FFFF);
      chk("timeout_err1", last_err1, 1'b1);
      chk("timeout_ready0", r0_cnt, 0);

      // ack on the last allowed ISSUE cycle
      do_reset();
      reqs_left[0] = 1; mode = 1;
      wait_ext_valid();
      repeat (3) @(posedge clk);
      #2; er = 1'b1; erd = 32'd5;
      @(posedge clk); #2; er = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk("boundary_ready0", r0_cnt, 1);
      chk("boundary_rd0", last_rd0, 32'd5);
      chk("boundary_err0", last_err0, 1'b0);
      chk("boundary_ext_cycles", ev_cnt, TO);

      // reset in the middle of ISSUE
      do_reset();
      reqs_left[0] = 1; mode = 1;
      wait_ext_valid();
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("midrst_ext_valid", o_ext_valid, 1'b0);
      quiet_inputs();
      repeat (2) @(posedge clk);
      #2; rst = 1'b0;
      er = 1'b1; erd = 32'hABCD; reqs_left[1] = 1; mode = 1;
      for (int i = 0; i < 30 && r1_cnt == 0; i++) @(negedge clk);
      repeat (4) @(posedge clk);
      #2;
      chk("midrst_ready1", r1_cnt, 1);
      chk("midrst_rd1", last_rd1, 32'hABCD);
      chk("midrst_no_ready0", r0_cnt, 0);

      // random traffic with occasional resets
      do_reset();
      mode = 2;
      repeat (6) begin
         repeat ($urandom_range(300, 600)) @(posedge clk);
         #2; rst = 1'b1;
         @(posedge clk);
         #2; rst = 1'b0;
      end
      repeat (200) @(posedge clk);
      #2;
      chk("random_served0", (r0_cnt > 0), 1'b1);
      chk("random_served1", (r1_cnt > 0), 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
